// File: rtl/qsys_serial_pkg.sv
// qsys_serial_pkg: frame geometry, response constants and FSM states for the serial responder
package qsys_serial_pkg;
  localparam int unsigned FRAME_BITS = 65;
  localparam int unsigned RESP_BITS = 32;
  localparam int unsigned RW_BIT = 64;
  localparam int unsigned ADDR_MSB = 63;
  localparam int unsigned ADDR_LSB = 32;
  localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {IDLE, RX, EXEC, GAP, TX} state_e;
endpackage

// File: rtl/qsys_serial_shifter.sv
// qsys_serial_shifter: MSB-first shift register with serial in/out and parallel load/out
module qsys_serial_shifter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         shift_i,
  input  logic         sin_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  output logic         sout_o,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;
  // load has priority over shift
  always_comb q_d = load_i ? load_data_i : shift_i ? {q_q[W-2:0], sin_i} : q_q;
  // shift register state
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
  assign sout_o = q_q[W-1];
endmodule

// File: rtl/qsys_serial_responder.sv
// qsys_serial_responder: serial command frames to local Avalon-MM accesses with serial responses
module qsys_serial_responder
  import qsys_serial_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset_n,
  input  logic              sdi,
  input  logic              sle,
  output logic              sdo,
  output logic              srdy,
  output logic [ADDR_W-1:0] avm_local_address,
  output logic [31:0]       avm_local_writedata,
  output logic [3:0]        avm_local_byteenable,
  output logic              avm_local_write,
  output logic              avm_local_read,
  input  logic [31:0]       avm_local_readdata,
  input  logic              avm_local_waitrequest,
  output logic              frame_err,
  output logic              bus_err
);
  state_e state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [15:0] wait_q, wait_d;
  logic [4:0] tcnt_q, tcnt_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic sle_q, ferr_q, ferr_d, berr_q, berr_d;
  logic [FRAME_BITS-1:0] rx_q;
  logic [RESP_BITS-1:0] tx_q;
  logic rx_sout, tx_sout, rw, unused_bits;

  qsys_serial_shifter #(.W(FRAME_BITS)) u_rx (
    .clk_i(csi_MCLK_clk), .rst_ni(rsi_MRST_reset_n),
    .shift_i(sle && (state_q == IDLE || state_q == RX)), .sin_i(sdi),
    .load_i(1'b0), .load_data_i('0), .sout_o(rx_sout), .q_o(rx_q)
  );

  qsys_serial_shifter #(.W(RESP_BITS)) u_tx (
    .clk_i(csi_MCLK_clk), .rst_ni(rsi_MRST_reset_n),
    .shift_i(state_q == TX), .sin_i(1'b0),
    .load_i(state_q == GAP), .load_data_i(resp_q), .sout_o(tx_sout), .q_o(tx_q)
  );

  assign rw = rx_q[RW_BIT];
  assign unused_bits = ^{rx_sout, rx_q[ADDR_MSB:ADDR_LSB], tx_q};

  // next state, counters, response word and error pulses
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wait_d = wait_q;
    tcnt_d = tcnt_q;
    resp_d = resp_q;
    ferr_d = sle && !sle_q && state_q != IDLE && state_q != RX;
    berr_d = 1'b0;
    case (state_q)
      IDLE: if (sle) begin
        state_d = RX;
        cnt_d = 7'd1;
      end
      RX: if (sle) cnt_d = cnt_q == 7'(FRAME_BITS + 1) ? cnt_q : cnt_q + 7'd1;
        else if (cnt_q == 7'(FRAME_BITS)) begin
          state_d = EXEC;
          wait_d = '0;
        end else begin
          state_d = IDLE;
          ferr_d = 1'b1;
        end
      EXEC: if (!avm_local_waitrequest) begin
        state_d = GAP;
        resp_d = rw ? '0 : avm_local_readdata;
      end else if (wait_q == 16'(TIMEOUT - 1)) begin
        state_d = GAP;
        resp_d = TIMEOUT_FILL;
        berr_d = 1'b1;
      end else wait_d = wait_q + 16'd1;
      GAP: begin
        state_d = TX;
        tcnt_d = '0;
      end
      TX: begin
        tcnt_d = tcnt_q + 5'd1;
        state_d = tcnt_q == 5'd31 ? IDLE : TX;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and bookkeeping registers
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n)
    if (!rsi_MRST_reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wait_q <= '0;
      tcnt_q <= '0;
      resp_q <= '0;
      sle_q <= 1'b0;
      ferr_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
      tcnt_q <= tcnt_d;
      resp_q <= resp_d;
      sle_q <= sle;
      ferr_q <= ferr_d;
      berr_q <= berr_d;
    end

  assign avm_local_write = state_q == EXEC && rw;
  assign avm_local_read = state_q == EXEC && !rw;
  assign avm_local_address = rx_q[ADDR_LSB +: ADDR_W];
  assign avm_local_writedata = rx_q[31:0];
  assign avm_local_byteenable = 4'hF;
  assign srdy = state_q == TX;
  assign sdo = srdy && tx_sout;
  assign frame_err = ferr_q;
  assign bus_err = berr_q;
endmodule

// File: tb/tb_qsys_serial_responder.sv
// tb_qsys_serial_responder: directed frames checked every cycle against a cycle-indexed expectation model
module tb_qsys_serial_responder;
  localparam int TO = 4;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic sdi = 1'b0, sle = 1'b0, waitreq = 1'b0;
  logic [31:0] readdata = '0;
  logic sdo, srdy, wr, rd, frame_err, bus_err;
  logic [7:0] addr;
  logic [31:0] wdata;
  logic [3:0] be;

  qsys_serial_responder #(.ADDR_W(8), .TIMEOUT(TO)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n), .sdi(sdi), .sle(sle),
    .sdo(sdo), .srdy(srdy), .avm_local_address(addr), .avm_local_writedata(wdata),
    .avm_local_byteenable(be), .avm_local_write(wr), .avm_local_read(rd),
    .avm_local_readdata(readdata), .avm_local_waitrequest(waitreq),
    .frame_err(frame_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic exp_srdy[DEPTH], exp_sdo[DEPTH], exp_wr[DEPTH], exp_rd[DEPTH];
  logic [7:0] exp_addr[DEPTH];
  logic [31:0] exp_wd[DEPTH];
  int n_checks = 0, n_fail = 0;
  int ferr_seen = 0, berr_seen = 0, exp_ferr = 0, exp_berr = 0;
  int srdy_rise = 0, stb_len = 0;
  logic srdy_p = 1'b0, stb_p = 1'b0;
  logic [31:0] sdo_word = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < DEPTH; i++) begin
      exp_srdy[i] = 0; exp_sdo[i] = 0; exp_wr[i] = 0; exp_rd[i] = 0;
      exp_addr[i] = '0; exp_wd[i] = '0;
    end
  endtask

  // What the link must do for one accepted frame whose closing sle=0 is sampled in cycle n
  task automatic expect_txn(input int n, input bit w, input logic [7:0] a, input logic [31:0] d,
                            input int waits, input logic [31:0] rdata);
    int k;
    logic [31:0] resp;
    k = waits >= TO ? TO : waits + 1;
    resp = waits >= TO ? 32'hFFFF_FFFF : (w ? 32'h0 : rdata);
    for (int j = 1; j <= k; j++) begin
      exp_wr[n + j] = w; exp_rd[n + j] = !w; exp_addr[n + j] = a; exp_wd[n + j] = d;
    end
    for (int b = 0; b < 32; b++) begin
      exp_srdy[n + k + 2 + b] = 1'b1;
      exp_sdo[n + k + 2 + b] = resp[31 - b];
    end
    if (waits >= TO) exp_berr++;
  endtask

  // single compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (cyc < DEPTH) begin
      chk("srdy", srdy, exp_srdy[cyc]);
      chk("sdo", sdo, exp_sdo[cyc]);
      chk("write", wr, exp_wr[cyc]);
      chk("read", rd, exp_rd[cyc]);
      chk("byteenable", be, 4'hF);
      if (exp_wr[cyc] || exp_rd[cyc]) chk("address", addr, exp_addr[cyc]);
      if (exp_wr[cyc]) chk("writedata", wdata, exp_wd[cyc]);
    end
    ferr_seen += int'(frame_err);
    berr_seen += int'(bus_err);
    if (srdy && !srdy_p) srdy_rise = cyc;
    if (srdy) sdo_word = {sdo_word[30:0], sdo};
    if (wr || rd) stb_len = stb_p ? stb_len + 1 : 1;
    srdy_p = srdy;
    stb_p = wr || rd;
  end

  task automatic send_bits(input logic [64:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      sle = 1'b1;
      sdi = i < 65 ? f[64 - i] : 1'($urandom);
    end
  endtask

  task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d, input int waits,
                         input logic [31:0] rdata, input bit pulse, output int n);
    int k, t;
    readdata = rdata;
    send_bits({w, a, d}, 65);
    @(negedge clk);
    sle = 1'b0;
    sdi = 1'b0;
    n = cyc;
    expect_txn(n, w, a[7:0], d, waits, rdata);
    if (pulse) exp_ferr++;
    k = waits >= TO ? TO : waits + 1;
    t = n;
    while (t < n + k + 36) begin
      @(negedge clk);
      t = cyc;
      waitreq = (t - n - 1) < waits;
      sle = pulse && t >= n + k + 10 && t < n + k + 13;
      sdi = 1'b1;
    end
    waitreq = 1'b0;
    sle = 1'b0;
    sdi = 1'b0;
  endtask

  task automatic bad_frame(input int len);
    send_bits('0, len);
    @(negedge clk);
    sle = 1'b0;
    exp_ferr++;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    clear_from(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset frame_err", frame_err, 0);
    chk("reset bus_err", bus_err, 0);
    chk("reset address", addr, 0);
    chk("reset writedata", wdata, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(1'b1, 32'h0000_0012, 32'hCAFE_F00D, 0, 32'h0, 1'b0, n);
    chk("write srdy latency", srdy_rise - n, 3);
    chk("write strobe length", stb_len, 1);
    chk("write response", sdo_word, 32'h0);

    run_txn(1'b0, 32'hFF00_0034, 32'h1357_9BDF, 3, 32'hA5A5_0F0F, 1'b0, n);
    chk("read srdy latency", srdy_rise - n, 6);
    chk("read strobe length", stb_len, 4);
    chk("read response", sdo_word, 32'hA5A5_0F0F);

    run_txn(1'b0, 32'h0000_0056, 32'h0, 100, 32'h1234_5678, 1'b0, n);
    chk("timeout strobe length", stb_len, TO);
    chk("timeout response", sdo_word, 32'hFFFF_FFFF);
    chk("bus_err pulses", berr_seen, exp_berr);

    bad_frame(40);
    chk("frame_err short", ferr_seen, exp_ferr);
    bad_frame(70);
    chk("frame_err long", ferr_seen, exp_ferr);

    run_txn(1'b0, 32'h0000_0077, 32'h0, 1, 32'h0F1E_2D3C, 1'b1, n);
    chk("frame_err during TX", ferr_seen, exp_ferr);
    chk("response under sle pulse", sdo_word, 32'h0F1E_2D3C);

    send_bits({1'b1, 32'h0000_00AB, 32'hDEAD_BEEF}, 30);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_from(cyc);
    #1;
    chk("async reset writedata", wdata, 0);
    chk("async reset srdy", srdy, 0);
    @(negedge clk);
    sle = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    readdata = 32'h0;
    send_bits({1'b0, 32'h0000_0099, 32'h0}, 65);
    @(negedge clk);
    sle = 1'b0;
    waitreq = 1'b1;
    n = cyc;
    expect_txn(n, 1'b0, 8'h99, 32'h0, 100, 32'h0);
    exp_berr--;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_from(cyc);
    #1;
    chk("async reset read", rd, 0);
    chk("async reset address", addr, 0);
    waitreq = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(1'b1, 32'h0000_00C3, 32'h8421_0FED, 2, 32'h0, 1'b0, n);
    chk("post-reset write latency", srdy_rise - n, 5);
    chk("post-reset response", sdo_word, 32'h0);
    chk("final frame_err pulses", ferr_seen, exp_ferr);
    chk("final bus_err pulses", berr_seen, exp_berr);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qsys_serial_responder.md
# qsys_serial_responder

Device-side end of the Qsys serial link. Receives 65-bit command frames on `sdi` qualified by `sle`, executes each as a single 32-bit access on a local Avalon-MM master port, then returns a 32-bit response on `sdo` framed by `srdy`. It sits on the remote board or FPGA and bridges the serial link into that side's local register space.

## Interface
- `ADDR_W`, default 8: local address width. Uses frame address bits [ADDR_W-1:0]; upper address bits are ignored.
- `TIMEOUT`, default 255: maximum number of `avm_local_waitrequest` cycles before the access is abandoned. Range 1..65535.
- `csi_MCLK_clk`, in, 1: the single clock, the same clock the initiator forwards on its `clk` pin.
- `rsi_MRST_reset_n`, in, 1: asynchronous, active-low reset.
- `sdi`, in, 1: serial command data, MSB first.
- `sle`, in, 1: frame enable. High while command bits are valid.
- `sdo`, out, 1: serial response data, MSB first.
- `srdy`, out, 1: response valid. High for exactly 32 cycles per response.
- `avm_local_address`, out, ADDR_W: local access address.
- `avm_local_writedata`, out, 32: local write data.
- `avm_local_byteenable`, out, 4: constant 4'hF.
- `avm_local_write` / `avm_local_read`, out, 1 each: access strobes.
- `avm_local_readdata`, in, 32: local read data.
- `avm_local_waitrequest`, in, 1: local stall.
- `frame_err`, out, 1: one-cycle pulse on a malformed frame.
- `bus_err`, out, 1: one-cycle pulse on an access timeout.

## Operation
- Frame layout, 65 bits, MSB first:
  - bit 64: R/W, 1 = write.
  - bits 63:32: address.
  - bits 31:0: write data. The bits are don't-care on reads.
- Receive path: shift `sdi` into a 65-bit register on every rising edge where `sle`=1. The bit counter saturates at 66.
- State machine:
  - IDLE: `sle`=1 → RX, capturing the first bit with count=1.
  - RX: `sle`=1 → shift and increment count. `sle`=0 with count==65 → EXEC. `sle`=0 with any other count → IDLE and pulse `frame_err`.
  - EXEC:
    - Drive `avm_local_read` or `avm_local_write`, plus address and data, for every EXEC cycle.
    - Complete in the cycle where `avm_local_waitrequest`=0. A read captures `avm_local_readdata` in that cycle; a write's response word is 32'h0.
    - If the wait count reaches TIMEOUT, drop the strobe, set the response to 32'hFFFF_FFFF and pulse `bus_err`.
    - Either outcome → GAP.
  - GAP: one turnaround cycle with `srdy`=0. Load the response shifter.
  - TX: `srdy`=1 and `sdo`=response bit 31-k on the k-th TX cycle. After 32 cycles → IDLE.
- `sle` rising while in EXEC, GAP or TX: the bits are ignored, `frame_err` pulses once on that rising edge, and the current transaction completes normally.
- Strobes, address, writedata, `sdo` and `srdy` are decoded or registered from the state register, so they are glitch-free.

## Timing
- Reset values:
  - `sdo`=0, `srdy`=0.
  - Strobes 0, `avm_local_address`=0, `avm_local_writedata`=0.
  - `frame_err`=0, `bus_err`=0.
  - State IDLE, counters 0.
- Reset is asynchronous and may be asserted mid-frame or mid-access. Every output returns to its reset value immediately, and a partial frame is discarded.
- Latency with zero wait states:
  - Cycle N: first edge sampling `sle`=0 after 65 bits.
  - Cycle N+1: EXEC, strobe high for one cycle.
  - Cycle N+2: GAP.
  - Cycle N+3: `srdy`=1 with bit 31 on `sdo`.
  - Cycle N+35: `srdy` is 0 again.
- Each wait-state cycle adds one cycle. A timeout path holds the strobe for exactly TIMEOUT cycles.
- Back-to-back: a new frame is accepted starting at the first IDLE cycle after TX.
- `sdo` holds 0 whenever `srdy`=0.

## Structure
- Package `qsys_serial_pkg` holds:
  - FRAME_BITS=65, RESP_BITS=32, RW_BIT=64.
  - ADDR_MSB=63, ADDR_LSB=32.
  - TIMEOUT_FILL=32'hFFFF_FFFF.
  - The state enum: IDLE, RX, EXEC, GAP, TX.
- One sub-module: `qsys_serial_shifter`, a parameterized-width shift register with serial in, serial out, parallel load and parallel out. Instantiate it twice: 65 bits for receive, 32 bits for transmit.

## Test plan
- Write frame {1, 32'h0000_0012, 32'hCAFE_F00D}, zero waits → one-cycle `avm_local_write`, address 8'h12, data CAFEF00D; `srdy` high 32 cycles starting N+3; `sdo` all zeros.
- Read frame for address 8'h34, readdata 32'hA5A5_0F0F after 3 wait states → `avm_local_read` high 4 cycles; `sdo` serializes A5A50F0F MSB first; `srdy` rises at N+6.
- Read with waitrequest stuck high, TIMEOUT=4 → strobe high 4 cycles; `bus_err` pulses once; response FFFFFFFF.
- `sle` high 40 cycles, then 70 cycles → `frame_err` pulse on each; no strobes; `srdy` stays 0.
- `sle` pulsed during TX → `frame_err` pulse; current response still completes all 32 bits intact.
- Reset asserted mid-RX (bit 30) and again mid-EXEC with waitrequest high → all outputs return to reset values at once; the next full write frame executes correctly.
